// File: rtl/id_ex_stage_if.sv
// Decode->execute stage bundle: upstream handshake and operands, forwarding
// sources, flush, downstream handshake and payload, stall statistics.
interface id_ex_stage_if #(parameter int CNT_W = 16);
   logic             in_valid, in_ready;
   logic [31:0]      in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]       in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic [10:0]      in_aluop;
   logic             in_use_pc, in_use_imm, in_reg_write, in_is_load;
   logic [4:0]       exmem_rd, memwb_rd;
   logic             exmem_reg_write, memwb_reg_write;
   logic [31:0]      exmem_result, memwb_result;
   logic             flush;
   logic             out_valid, out_ready;
   logic [31:0]      out_a, out_b, out_store_data, out_pc;
   logic [10:0]      out_aluop;
   logic [4:0]       out_rd_addr;
   logic             out_reg_write, out_is_load;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
             in_rs1_addr, in_rs2_addr, in_rd_addr, in_aluop,
             in_use_pc, in_use_imm, in_reg_write, in_is_load,
             exmem_rd, exmem_reg_write, exmem_result,
             memwb_rd, memwb_reg_write, memwb_result, flush, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_store_data, out_pc,
             out_aluop, out_rd_addr, out_reg_write, out_is_load, stall_count
   );

   modport slave (
      input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
             in_rs1_addr, in_rs2_addr, in_rd_addr, in_aluop,
             in_use_pc, in_use_imm, in_reg_write, in_is_load,
             exmem_rd, exmem_reg_write, exmem_result,
             memwb_rd, memwb_reg_write, memwb_result, flush, out_ready,
      output in_ready, out_valid, out_a, out_b, out_store_data, out_pc,
             out_aluop, out_rd_addr, out_reg_write, out_is_load, stall_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use interlock,
// flush, valid/ready backpressure and a saturating stall counter.
module id_ex_stage #(
   parameter int CNT_W = 16
) (
   input logic        clk,
   input logic        rst,
   id_ex_stage_if.slave bus
);
   logic             outValid;
   logic [31:0]      outA, outB, outStoreData, outPc;
   logic [10:0]      outAluop;
   logic [4:0]       outRdAddr;
   logic             outRegWrite, outIsLoad;
   logic [CNT_W-1:0] stallCnt;

   logic [31:0] fwdRs1, fwdRs2;
   logic        loadUse, inReady, accept;

   // EX/MEM is younger than MEM/WB, so it wins when both target the register.
   function automatic logic [31:0] fwdOperand(
      input logic [4:0]  addr,
      input logic [31:0] regData,
      input logic        exWr,
      input logic [4:0]  exRd,
      input logic [31:0] exRes,
      input logic        wbWr,
      input logic [4:0]  wbRd,
      input logic [31:0] wbRes
   );
      if (addr != 5'd0 && exWr && exRd == addr)      return exRes;
      else if (addr != 5'd0 && wbWr && wbRd == addr) return wbRes;
      else                                           return regData;
   endfunction

   always_comb begin
      fwdRs1 = fwdOperand(bus.in_rs1_addr, bus.in_rs1_data,
                          bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                          bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
      fwdRs2 = fwdOperand(bus.in_rs2_addr, bus.in_rs2_data,
                          bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                          bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
   end

   // Held load's data isn't available until it reaches MEM/WB: hold off one cycle.
   assign loadUse = outValid && outIsLoad && (outRdAddr != 5'd0) &&
                    ((outRdAddr == bus.in_rs1_addr) || (outRdAddr == bus.in_rs2_addr));
   assign inReady = (!outValid || bus.out_ready) && !loadUse;
   assign accept  = bus.in_valid && inReady && !bus.flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outValid     <= 1'b0;
         outA         <= '0;
         outB         <= '0;
         outStoreData <= '0;
         outPc        <= '0;
         outAluop     <= '0;
         outRdAddr    <= '0;
         outRegWrite  <= 1'b0;
         outIsLoad    <= 1'b0;
         stallCnt     <= '0;
      end else begin
         if (bus.flush) begin
            outValid <= 1'b0;
         end else if (accept) begin
            outValid     <= 1'b1;
            outA         <= bus.in_use_pc  ? bus.in_pc  : fwdRs1;
            outB         <= bus.in_use_imm ? bus.in_imm : fwdRs2;
            outStoreData <= fwdRs2;
            outPc        <= bus.in_pc;
            outAluop     <= bus.in_aluop;
            outRdAddr    <= bus.in_rd_addr;
            outRegWrite  <= bus.in_reg_write;
            outIsLoad    <= bus.in_is_load;
         end else if (outValid && bus.out_ready) begin
            outValid <= 1'b0;
         end
         if (bus.in_valid && !inReady && !bus.flush && stallCnt != '1)
            stallCnt <= stallCnt + CNT_W'(1);
      end
   end

   assign bus.in_ready       = inReady;
   assign bus.out_valid      = outValid;
   assign bus.out_a          = outA;
   assign bus.out_b          = outB;
   assign bus.out_store_data = outStoreData;
   assign bus.out_pc         = outPc;
   assign bus.out_aluop      = outAluop;
   assign bus.out_rd_addr    = outRdAddr;
   assign bus.out_reg_write  = outRegWrite;
   assign bus.out_is_load    = outIsLoad;
   assign bus.stall_count    = stallCnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed checks of id_ex_stage: throughput, forwarding, backpressure,
// load-use interlock, flush and asynchronous reset.
module tb_id_ex_stage;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   id_ex_stage_if #(.CNT_W(CNT_W)) bus ();
   id_ex_stage #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic setIn(input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
                        input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic usePc, input logic useImm,
                        input logic isLoad);
      bus.in_pc        = pc;
      bus.in_rs1_data  = rs1d;
      bus.in_rs2_data  = rs2d;
      bus.in_imm       = imm;
      bus.in_rs1_addr  = rs1;
      bus.in_rs2_addr  = rs2;
      bus.in_rd_addr   = rd;
      bus.in_aluop     = 11'h001;
      bus.in_use_pc    = usePc;
      bus.in_use_imm   = useImm;
      bus.in_reg_write = 1'b1;
      bus.in_is_load   = isLoad;
   endtask

   task automatic setFwd(input logic exWr, input logic [4:0] exRd, input logic [31:0] exRes,
                         input logic wbWr, input logic [4:0] wbRd, input logic [31:0] wbRes);
      bus.exmem_reg_write = exWr;
      bus.exmem_rd        = exRd;
      bus.exmem_result    = exRes;
      bus.memwb_reg_write = wbWr;
      bus.memwb_rd        = wbRd;
      bus.memwb_result    = wbRes;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      setIn(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #2;
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_a", bus.out_a, 32'h0);
      chk("reset_stall_count", 32'(bus.stall_count), 32'd0);
      tick();
      rst = 1'b0;

      // Back-to-back ALU ops
      bus.in_valid = 1'b1;
      setIn(32'h10, 32'h100, 32'h200, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
      tick();
      chk("b2b1_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b1_a", bus.out_a, 32'h100);
      chk("b2b1_b", bus.out_b, 32'h200);
      setIn(32'h40, 32'h1, 32'h2, 32'h8, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);
      tick();
      chk("b2b2_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b2_a_pc", bus.out_a, 32'h40);
      chk("b2b2_b_imm", bus.out_b, 32'h8);
      chk("b2b2_store_rs2", bus.out_store_data, 32'h2);
      setIn(32'h44, 32'h7, 32'h9, 32'h0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0);
      tick();
      chk("b2b3_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b3_a", bus.out_a, 32'h7);
      chk("b2b3_b", bus.out_b, 32'h9);
      chk("b2b3_rd", 32'(bus.out_rd_addr), 32'd5);
      bus.in_valid = 1'b0;
      tick();
      chk("b2b_bubble", 32'(bus.out_valid), 32'd0);
      chk("b2b_stall_count", 32'(bus.stall_count), 32'd0);

      // Forwarding priority and index-0 rule
      bus.in_valid = 1'b1;
      setIn(32'h50, 32'hdead, 32'hbeef, 32'h0, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0);
      setFwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
      tick();
      chk("fwd_exmem_a", bus.out_a, 32'h11);
      chk("fwd_exmem_b", bus.out_b, 32'h11);
      setFwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd5, 32'h22);
      tick();
      chk("fwd_memwb_a", bus.out_a, 32'h22);
      setIn(32'h54, 32'h33, 32'h44, 32'h0, 5'd0, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0);
      setFwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
      tick();
      chk("fwd_r0_a", bus.out_a, 32'h33);
      chk("fwd_r0_b", bus.out_b, 32'h44);
      setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Backpressure: 4 cycles of out_ready=0 with a pending input
      bus.out_ready = 1'b0;
      setIn(32'h58, 32'haaa, 32'hbbb, 32'h0, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         tick();
         chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_hold_a", bus.out_a, 32'h33);
      end
      chk("bp_stall_count", 32'(bus.stall_count), 32'd4);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_a", bus.out_a, 32'haaa);
      bus.in_valid = 1'b0;
      tick();
      chk("bp_drain", 32'(bus.out_valid), 32'd0);

      // Load-use: load x7 held, dependent reads x7 as rs2
      bus.in_valid = 1'b1;
      setIn(32'h60, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1);
      tick();
      chk("lu_load_valid", 32'(bus.out_valid), 32'd1);
      chk("lu_load_flag", 32'(bus.out_is_load), 32'd1);
      setIn(32'h64, 32'h66, 32'h55, 32'h0, 5'd1, 5'd7, 5'd8, 1'b0, 1'b0, 1'b0);
      setFwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
      #1;
      chk("lu_in_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
      chk("lu_bubble", 32'(bus.out_valid), 32'd0);
      chk("lu_stall_count", 32'(bus.stall_count), 32'd5);
      chk("lu_in_ready_high", 32'(bus.in_ready), 32'd1);
      tick();
      chk("lu_dep_valid", 32'(bus.out_valid), 32'd1);
      chk("lu_dep_b", bus.out_b, 32'h77);
      chk("lu_dep_rd", 32'(bus.out_rd_addr), 32'd8);
      chk("lu_stall_count2", 32'(bus.stall_count), 32'd5);
      setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Flush drops held and incoming instruction
      setIn(32'h68, 32'hccc, 32'hddd, 32'h0, 5'd1, 5'd2, 5'd10, 1'b0, 1'b0, 1'b0);
      bus.flush = 1'b1;
      tick();
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      chk("flush_no_capture_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_no_capture_a", bus.out_a, 32'h66);
      chk("flush_stall_count", 32'(bus.stall_count), 32'd5);

      // Asynchronous reset mid-stall, then accept right after release
      bus.in_valid = 1'b1;
      setIn(32'h70, 32'heee, 32'h0, 32'h0, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ar_pre_valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b0;
      tick();
      chk("ar_pre_stall", 32'(bus.stall_count), 32'd6);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid_cleared", 32'(bus.out_valid), 32'd0);
      chk("ar_stall_cleared", 32'(bus.stall_count), 32'd0);
      chk("ar_a_cleared", bus.out_a, 32'h0);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      setIn(32'h74, 32'hfff, 32'h0, 32'h0, 5'd1, 5'd2, 5'd12, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ar_accept_valid", 32'(bus.out_valid), 32'd1);
      chk("ar_accept_a", bus.out_a, 32'hfff);
      bus.in_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports in_valid in 1 and in_ready out 1  upstream handshake from decode.
REQ-005 SHALL have ports in_pc, in_rs1_data, in_rs2_data, in_imm  in  32 each  decoded operands.
REQ-006 SHALL have ports in_rs1_addr, in_rs2_addr, in_rd_addr  in  5 each  register indices.
REQ-007 SHALL have ports in_aluop in 11, in_use_pc in 1, in_use_imm in 1, in_reg_write in 1, in_is_load in 1.
REQ-008 SHALL have ports exmem_rd in 5, exmem_reg_write in 1, exmem_result in 32  EX/MEM forwarding source.
REQ-009 SHALL have ports memwb_rd in 5, memwb_reg_write in 1, memwb_result in 32  MEM/WB forwarding source.
REQ-010 SHALL have port flush  in  1  squash held and incoming instruction (taken branch/exception).
REQ-011 SHALL have ports out_valid out 1 and out_ready in 1  downstream handshake to ALU/EX.
REQ-012 SHALL have ports out_a, out_b, out_store_data, out_pc  out  32 each; out_aluop out 11; out_rd_addr out 5; out_reg_write out 1; out_is_load out 1.
REQ-013 SHALL have port stall_count  out  CNT_W  cycles in_ready was low while in_valid was high.

Function
REQ-014 Forwarded rs1 SHALL be exmem_result if exmem_reg_write and exmem_rd==in_rs1_addr and addr!=0, else memwb_result under the same rule for MEM/WB, else in_rs1_data; rs2 likewise.
REQ-015 EX/MEM SHALL take priority over MEM/WB when both match; index 0 SHALL never be forwarded.
REQ-016 Captured out_a SHALL be in_pc if in_use_pc else forwarded rs1; out_b SHALL be in_imm if in_use_imm else forwarded rs2.
REQ-017 out_store_data SHALL be forwarded rs2 regardless of in_use_imm.
REQ-018 load_use SHALL be asserted when out_valid and out_is_load and out_rd_addr!=0 and out_rd_addr equals in_rs1_addr or in_rs2_addr.
REQ-019 in_ready SHALL equal (!out_valid or out_ready) and !load_use, combinationally.
REQ-020 Accept = in_valid and in_ready and !flush; on accept all out_* payload registers SHALL load next edge and out_valid SHALL be 1.
REQ-021 When out_valid and out_ready and no accept, out_valid SHALL clear next edge (bubble); payload may hold stale values.
REQ-022 While out_valid and !out_ready, all out_* SHALL hold stable.
REQ-023 Load-use stall SHALL insert exactly one bubble: held load drains, then dependent instruction is accepted with MEM/WB forwarding.
REQ-024 flush SHALL clear out_valid next edge and drop any simultaneous input; flush dominates accept and stall.
REQ-025 stall_count SHALL increment by 1 each cycle in_valid and !in_ready and !flush, saturating at all-ones.
REQ-026 Latency in_valid accept to out_valid SHALL be exactly 1 cycle; throughput 1 per cycle when out_ready held high.

Reset
REQ-027 On rst high, out_valid, all out_* payloads and stall_count SHALL be 0 immediately, without waiting for clk.
REQ-028 rst mid-stall SHALL discard held instruction; first edge after rst release SHALL accept if in_valid.

Verification
REQ-029 Back-to-back: 3 ALU ops, out_ready=1 -> out_valid 1 for 3 consecutive cycles, out_a/out_b match inputs, stall_count=0.
REQ-030 Forwarding: rs1=5, exmem_rd=5 result 0x11, memwb_rd=5 result 0x22 -> out_a=0x11; exmem_rd=0 -> out_a=0x22; rs1=0 with matches -> in_rs1_data.
REQ-031 Load-use: load rd=7 held, next in rs2=7 -> in_ready=0 one cycle, stall_count=1, then accepted with out_b=memwb_result.
REQ-032 Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> outputs stable, in_ready=0, stall_count=4.
REQ-033 Flush: flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, input not captured.
REQ-034 Async reset: assert rst between edges with out_valid=1 -> out_valid and stall_count 0 before next edge.
